lsu_ctrl: RTL and testbench
===========================

// Module: lsu_ctrl
// PURPOSE
// Load/store request controller between the execute stage and the data-memory port.
// Accepts one load/store per transaction from EXU over valid/ready.
// Issues a word-aligned, byte-masked access to memory and waits for the load data.
// Extracts and sign/zero-extends the loaded data, then returns it to write-back over valid/ready.
// PARAMETERS
// AW  32  address width
// DW  32  data width (fixed 32; byte mask is DW/8 = 4 bits)
// PORTS
// clk          in   1   clock
// rst          in   1   synchronous reset, active-high
// req_valid    in   1   EXU request valid
// req_ready    out  1   controller can accept a request
// req_ren      in   1   load request
// req_wen      in   1   store request (req_ren has priority if both set)
// req_memop    in   3   000 b, 001 h, 010 w, 100 bu, 101 hu
// req_addr     in   32  byte address (rs1+imm)
// req_wdata    in   32  store data (rs2), right-aligned
// mem_valid    out  1   memory access valid
// mem_ready    in   1   memory accepted access
// mem_wen      out  1   1 = write, 0 = read
// mem_addr     out  32  req_addr & 32'hFFFF_FFFC
// mem_wdata    out  32  store data shifted to byte lane
// mem_wmask    out  4   byte-enable mask (0 on reads)
// mem_rvalid   in   1   read data valid
// mem_rdata    in   32  aligned read word
// rsp_valid    out  1   result valid to WBU
// rsp_ready    in   1   WBU accepts result
// rsp_rdata    out  32  extended load data (0 for stores)
// rsp_err      out  1   misaligned-access flag (always 0 without MISALIGN_CHK_EN)
// BEHAVIOUR
// - FSM states: IDLE, REQ, WAIT, RSP. All outputs are registered or decoded from state.
// - Reset: state=IDLE. mem_valid, rsp_valid, rsp_err, mem_wen = 0. mem_addr, mem_wdata, mem_wmask, rsp_rdata = 0.
// - req_ready = (state==IDLE) && !rst.
// - IDLE: on req_valid&&req_ready, latch memop, addr[1:0], aligned address, mask and shifted wdata.
//   - Load or store: go to REQ.
//   - Neither ren nor wen: go to RSP with rsp_rdata=0.
// - REQ: mem_valid=1. All mem_* outputs are held stable until mem_ready.
//   - On mem_ready with a store: go to RSP.
//   - On mem_ready with a load: go to WAIT.
// - WAIT: mem_rvalid is sampled only in this state (earliest one cycle after the handshake).
//   - On mem_rvalid, register the extended data into rsp_rdata and go to RSP.
// - RSP: rsp_valid=1 and rsp_rdata/rsp_err are held stable; on rsp_ready go to IDLE.
//   - A new request is accepted no earlier than the cycle after.
// - Minimum latency: store accept -> rsp_valid in 2 cycles; load with 0-wait memory in 3 cycles.
// - Masks use off=addr[1:0].
//   - b: 4'b0001<<off, wdata={4{wdata[7:0]}}.
//   - h: 4'b0011<<{off[1],1'b0}, wdata={2{wdata[15:0]}}.
//   - w: 4'b1111.
// - Load extract: b/bu select byte off; h/hu select half off[1]. b/h sign-extend, bu/hu zero-extend.
// - Unused memop codes on loads: rdata passes through unmodified. On stores: mask 0, but the access is still issued.
// - Reset mid-operation: return to IDLE next edge and drop the transaction.
//   - mem_valid and rsp_valid are 0 the cycle after rst.
//   - A late mem_rvalid in IDLE/REQ/RSP is ignored.
// CONFIGURATION
// - MISALIGN_CHK_EN defined:
//   - h/hu with off[0]=1, or w with off!=0, is flagged misaligned.
//   - Misaligned requests go IDLE->RSP directly with rsp_err=1, rsp_rdata=0; no mem_valid, no memory write.
// - MISALIGN_CHK_EN undefined:
//   - No check; rsp_err is tied 0.
//   - Half accesses use off[1] only; word accesses ignore off.
// STRUCTURE
// - Package lsu_pkg: memop codes (MOP_B/H/W/BU/HU), FSM state encoding, function wmask(memop, off).
// - Sub-module lsu_load_align: combinational extract and extend of (memop, off, rdata).
// TESTING
// - sb addr 0x8000_0003 wdata 0x0000_00AB -> mem_addr 0x8000_0000, wmask 4'b1000, wdata[31:24]=0xAB, mem_wen=1, then rsp_valid with rdata 0.
// - lb off 2, mem_rdata 0x12F4_5678 -> rsp_rdata 0xFFFF_FFF4. Same with lbu -> 0x0000_00F4.
// - lhu addr 0x8000_0102, mem_rdata 0x8001_0000 -> mem_addr 0x8000_0100, rsp_rdata 0x0000_8001. lh -> 0xFFFF_8001.
// - mem_ready low 3 cycles in REQ, then rsp_ready low 2 cycles -> mem_* and rsp_* stable throughout, req_ready=0, exactly one access issued.
// - rst asserted in WAIT, mem_rvalid pulsed 1 cycle after -> state IDLE, no rsp_valid, req_ready=1 after rst drops.
// - lw addr 0x8000_0002: with MISALIGN_CHK_EN -> no mem_valid, rsp_err=1, rdata 0. Without -> mem_addr 0x8000_0000, rsp_err=0.

Source files
------------

// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store controller: memop encodings, the
// controller state type, the store byte-enable helper and the store lane
// replication helper.
// Optional feature macro used by lsu_ctrl: MISALIGN_CHK_EN.
// ---------------------------------------------------------------------------
package lsu_pkg;

   localparam logic [2:0] MOP_B  = 3'b000;
   localparam logic [2:0] MOP_H  = 3'b001;
   localparam logic [2:0] MOP_W  = 3'b010;
   localparam logic [2:0] MOP_BU = 3'b100;
   localparam logic [2:0] MOP_HU = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_RSP  = 2'd3
   } lsu_state_t;

   // Byte-enable mask for a store. Half accesses only look at off[1], so a
   // half store at an odd address lands on the containing aligned half.
   // Codes that are not a legal store width produce an empty mask.
   function automatic logic [3:0] wmask(input logic [2:0] memop, input logic [1:0] off);
      logic [3:0] m;
      case (memop)
         MOP_B:   m = 4'b0001 << off;
         MOP_H:   m = 4'b0011 << {off[1], 1'b0};
         MOP_W:   m = 4'b1111;
         default: m = 4'b0000;
      endcase
      return m;
   endfunction

   // Store data is replicated across every lane so the mask alone selects
   // which bytes memory actually writes.
   function automatic logic [31:0] store_lane(input logic [2:0] memop, input logic [31:0] wdata);
      logic [31:0] d;
      case (memop)
         MOP_B:   d = {4{wdata[7:0]}};
         MOP_H:   d = {2{wdata[15:0]}};
         default: d = wdata;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// ---------------------------------------------------------------------------
// lsu_load_align
// Combinational extraction and sign/zero extension of a loaded word.
// Ports:
//   memop  in  3   load width/sign code of the pending load
//   off    in  2   byte offset of the original address
//   rdata  in  32  aligned word returned by memory
//   data   out 32  extended result; unknown codes pass rdata through
// ---------------------------------------------------------------------------
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [2:0]  memop,
   input  logic [1:0]  off,
   input  logic [31:0] rdata,
   output logic [31:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Pick the addressed byte/half out of the word, then extend it according
   // to the memop. Words and unused codes are returned untouched.
   always_comb begin
      byte_sel = rdata[{off, 3'b000} +: 8];
      half_sel = off[1] ? rdata[31:16] : rdata[15:0];
      case (memop)
         MOP_B:   data = {{24{byte_sel[7]}}, byte_sel};
         MOP_BU:  data = {24'd0, byte_sel};
         MOP_H:   data = {{16{half_sel[15]}}, half_sel};
         MOP_HU:  data = {16'd0, half_sel};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_ctrl
// Load/store request controller between the execute stage and the data
// memory port. One transaction at a time: accept from EXU, issue a
// word-aligned byte-masked access, wait for load data, return the extended
// result to write-back.
// Optional feature: define MISALIGN_CHK_EN to flag misaligned half/word
// accesses (returned immediately with rsp_err=1, no memory access).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      EXU handshake
//   req_ren/req_wen          load/store select (ren wins)
//   req_memop                width/sign code
//   req_addr/req_wdata       byte address, right-aligned store data
//   mem_valid/mem_ready      memory access handshake
//   mem_wen/mem_addr         write select, aligned address
//   mem_wdata/mem_wmask      lane-replicated store data, byte enables
//   mem_rvalid/mem_rdata     load data return
//   rsp_valid/rsp_ready      WBU handshake
//   rsp_rdata/rsp_err        extended load data, misaligned flag
// ---------------------------------------------------------------------------
module lsu_ctrl
   import lsu_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_ren,
   input  logic          req_wen,
   input  logic [2:0]    req_memop,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_wdata,
   output logic          mem_valid,
   input  logic          mem_ready,
   output logic          mem_wen,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic [3:0]    mem_wmask,
   input  logic          mem_rvalid,
   input  logic [DW-1:0] mem_rdata,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_rdata,
   output logic          rsp_err
);

   lsu_state_t  state;
   logic [2:0]  memop_q;
   logic [1:0]  off_q;
   logic [31:0] load_data;
   logic        is_load;
   logic        is_store;
   logic        misaligned;

   assign req_ready = (state == S_IDLE) && !rst;
   assign is_load   = req_ren;
   assign is_store  = !req_ren && req_wen;

`ifdef MISALIGN_CHK_EN
   // Half accesses must be half-aligned and words word-aligned; bytes never
   // fault. Only real loads/stores can be flagged.
   always_comb begin
      misaligned = 1'b0;
      if (is_load || is_store) begin
         case (req_memop)
            MOP_H, MOP_HU: misaligned = req_addr[0];
            MOP_W:         misaligned = (req_addr[1:0] != 2'b00);
            default:       misaligned = 1'b0;
         endcase
      end
   end
`else
   assign misaligned = 1'b0;
`endif

   lsu_load_align u_align (
      .memop (memop_q),
      .off   (off_q),
      .rdata (mem_rdata),
      .data  (load_data)
   );

   // Single FSM owning every registered output. Everything the memory side
   // sees is captured at accept time and then held untouched until the
   // handshake, and the response is held until WBU takes it. mem_rvalid is
   // only looked at in S_WAIT, so stray data after a reset is dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         memop_q   <= MOP_B;
         off_q     <= 2'b00;
         mem_valid <= 1'b0;
         mem_wen   <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wmask <= 4'b0000;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  memop_q   <= req_memop;
                  off_q     <= req_addr[1:0];
                  mem_addr  <= {req_addr[AW-1:2], 2'b00};
                  mem_wen   <= is_store && !misaligned;
                  mem_wmask <= (is_store && !misaligned) ? wmask(req_memop, req_addr[1:0]) : 4'b0000;
                  mem_wdata <= (is_store && !misaligned) ? store_lane(req_memop, req_wdata) : '0;
                  rsp_rdata <= '0;
                  rsp_err   <= misaligned;
                  if ((is_load || is_store) && !misaligned) begin
                     mem_valid <= 1'b1;
                     state     <= S_REQ;
                  end else begin
                     rsp_valid <= 1'b1;
                     state     <= S_RSP;
                  end
               end
            end
            S_REQ: begin
               if (mem_ready) begin
                  mem_valid <= 1'b0;
                  if (mem_wen) begin
                     rsp_valid <= 1'b1;
                     state     <= S_RSP;
                  end else begin
                     state <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (mem_rvalid) begin
                  rsp_rdata <= load_data;
                  rsp_valid <= 1'b1;
                  state     <= S_RSP;
               end
            end
            S_RSP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lsu_ctrl
// Directed bench for lsu_ctrl. Every transaction is stepped edge by edge so
// latency and hold behaviour are checked exactly. Honors MISALIGN_CHK_EN.
// ---------------------------------------------------------------------------
module tb_lsu_ctrl;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_ren;
   logic        req_wen;
   logic [2:0]  req_memop;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        mem_valid;
   logic        mem_ready;
   logic        mem_wen;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wmask;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int checks;
   int errors;
   int access_count;
   int count_before;

   lsu_ctrl #(.AW(32), .DW(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_ren    (req_ren),
      .req_wen    (req_wen),
      .req_memop  (req_memop),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .mem_valid  (mem_valid),
      .mem_ready  (mem_ready),
      .mem_wen    (mem_wen),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_wmask  (mem_wmask),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err)
   );

   // Free-running 10ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts completed memory handshakes so repeated issues are caught.
   always @(posedge clk) begin
      if (mem_valid && mem_ready)
         access_count++;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: actual=0x%08h expected=0x%08h", tag, actual, expected);
      end
   endtask

   // Presents one request for exactly one cycle; the controller must be idle.
   task automatic applyStimulus(input string tag, input logic ren, input logic wen,
                                input logic [2:0] memop, input logic [31:0] addr,
                                input logic [31:0] wdata);
      checkOutput({tag, " req_ready idle"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_ren   = ren;
      req_wen   = wen;
      req_memop = memop;
      req_addr  = addr;
      req_wdata = wdata;
      tick();
      req_valid = 1'b0;
      req_ren   = 1'b0;
      req_wen   = 1'b0;
      req_addr  = 32'd0;
      req_wdata = 32'd0;
      checkOutput({tag, " req_ready busy"}, 32'(req_ready), 32'd0);
   endtask

   // Checks the issued access and completes the memory handshake.
   task automatic memAccess(input string tag, input logic [31:0] addr, input logic wen,
                            input logic [3:0] mask, input logic [31:0] wdata);
      checkOutput({tag, " mem_valid"}, 32'(mem_valid), 32'd1);
      checkOutput({tag, " mem_addr"},  mem_addr, addr);
      checkOutput({tag, " mem_wen"},   32'(mem_wen), 32'(wen));
      checkOutput({tag, " mem_wmask"}, 32'(mem_wmask), 32'(mask));
      checkOutput({tag, " mem_wdata"}, mem_wdata, wdata);
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      checkOutput({tag, " mem_valid drop"}, 32'(mem_valid), 32'd0);
   endtask

   task automatic loadReturn(input string tag, input logic [31:0] rdata);
      checkOutput({tag, " no early rsp"}, 32'(rsp_valid), 32'd0);
      mem_rvalid = 1'b1;
      mem_rdata  = rdata;
      tick();
      mem_rvalid = 1'b0;
      mem_rdata  = 32'd0;
   endtask

   task automatic rspAccept(input string tag, input logic [31:0] rdata, input logic err);
      checkOutput({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
      checkOutput({tag, " rsp_rdata"}, rsp_rdata, rdata);
      checkOutput({tag, " rsp_err"},   32'(rsp_err), 32'(err));
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      checkOutput({tag, " rsp_valid drop"}, 32'(rsp_valid), 32'd0);
   endtask

   initial begin
      checks       = 0;
      errors       = 0;
      access_count = 0;
      rst          = 1'b1;
      req_valid    = 1'b0;
      req_ren      = 1'b0;
      req_wen      = 1'b0;
      req_memop    = 3'b000;
      req_addr     = 32'd0;
      req_wdata    = 32'd0;
      mem_ready    = 1'b0;
      mem_rvalid   = 1'b0;
      mem_rdata    = 32'd0;
      rsp_ready    = 1'b0;

      $display("[TB] reset");
      tick();
      tick();
      checkOutput("rst req_ready",  32'(req_ready), 32'd0);
      checkOutput("rst mem_valid",  32'(mem_valid), 32'd0);
      checkOutput("rst rsp_valid",  32'(rsp_valid), 32'd0);
      checkOutput("rst rsp_err",    32'(rsp_err), 32'd0);
      checkOutput("rst mem_wen",    32'(mem_wen), 32'd0);
      checkOutput("rst mem_addr",   mem_addr, 32'd0);
      checkOutput("rst mem_wdata",  mem_wdata, 32'd0);
      checkOutput("rst mem_wmask",  32'(mem_wmask), 32'd0);
      checkOutput("rst rsp_rdata",  rsp_rdata, 32'd0);
      rst = 1'b0;
      #1;

      $display("[TB] stores");
      applyStimulus("sb", 1'b0, 1'b1, 3'b000, 32'h8000_0003, 32'h0000_00AB);
      memAccess("sb", 32'h8000_0000, 1'b1, 4'b1000, 32'hABAB_ABAB);
      rspAccept("sb", 32'd0, 1'b0);

      applyStimulus("sh", 1'b0, 1'b1, 3'b001, 32'h8000_0012, 32'hFFFF_1234);
      memAccess("sh", 32'h8000_0010, 1'b1, 4'b1100, 32'h1234_1234);
      rspAccept("sh", 32'd0, 1'b0);

      applyStimulus("sw", 1'b0, 1'b1, 3'b010, 32'h8000_0020, 32'hCAFE_F00D);
      memAccess("sw", 32'h8000_0020, 1'b1, 4'b1111, 32'hCAFE_F00D);
      rspAccept("sw", 32'd0, 1'b0);

      $display("[TB] loads");
      applyStimulus("lb", 1'b1, 1'b0, 3'b000, 32'h8000_0002, 32'hFFFF_FFFF);
      memAccess("lb", 32'h8000_0000, 1'b0, 4'b0000, 32'd0);
      loadReturn("lb", 32'h12F4_5678);
      rspAccept("lb", 32'hFFFF_FFF4, 1'b0);

      applyStimulus("lbu", 1'b1, 1'b0, 3'b100, 32'h8000_0002, 32'd0);
      memAccess("lbu", 32'h8000_0000, 1'b0, 4'b0000, 32'd0);
      loadReturn("lbu", 32'h12F4_5678);
      rspAccept("lbu", 32'h0000_00F4, 1'b0);

      applyStimulus("lhu", 1'b1, 1'b0, 3'b101, 32'h8000_0102, 32'd0);
      memAccess("lhu", 32'h8000_0100, 1'b0, 4'b0000, 32'd0);
      loadReturn("lhu", 32'h8001_0000);
      rspAccept("lhu", 32'h0000_8001, 1'b0);

      applyStimulus("lh", 1'b1, 1'b1, 3'b001, 32'h8000_0102, 32'h5555_5555);
      memAccess("lh", 32'h8000_0100, 1'b0, 4'b0000, 32'd0);
      loadReturn("lh", 32'h8001_0000);
      rspAccept("lh", 32'hFFFF_8001, 1'b0);

      applyStimulus("lw", 1'b1, 1'b0, 3'b010, 32'h8000_0010, 32'd0);
      memAccess("lw", 32'h8000_0010, 1'b0, 4'b0000, 32'd0);
      loadReturn("lw", 32'hDEAD_BEEF);
      rspAccept("lw", 32'hDEAD_BEEF, 1'b0);

      $display("[TB] no-op request");
      applyStimulus("nop", 1'b0, 1'b0, 3'b010, 32'h8000_0040, 32'd0);
      checkOutput("nop mem_valid", 32'(mem_valid), 32'd0);
      rspAccept("nop", 32'd0, 1'b0);

      $display("[TB] back-pressure");
      count_before = access_count;
      applyStimulus("stall", 1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'd0);
      for (int i = 0; i < 3; i++) begin
         checkOutput("stall req mem_valid", 32'(mem_valid), 32'd1);
         checkOutput("stall req mem_addr",  mem_addr, 32'h0000_0040);
         checkOutput("stall req mem_wmask", 32'(mem_wmask), 32'd0);
         checkOutput("stall req req_ready", 32'(req_ready), 32'd0);
         tick();
      end
      memAccess("stall", 32'h0000_0040, 1'b0, 4'b0000, 32'd0);
      loadReturn("stall", 32'h1357_9BDF);
      for (int i = 0; i < 2; i++) begin
         checkOutput("stall rsp_valid", 32'(rsp_valid), 32'd1);
         checkOutput("stall rsp_rdata", rsp_rdata, 32'h1357_9BDF);
         checkOutput("stall rsp_err",   32'(rsp_err), 32'd0);
         checkOutput("stall mem_valid", 32'(mem_valid), 32'd0);
         checkOutput("stall req_ready", 32'(req_ready), 32'd0);
         tick();
      end
      rspAccept("stall", 32'h1357_9BDF, 1'b0);
      checkOutput("stall access count", 32'(access_count - count_before), 32'd1);

      $display("[TB] reset during wait");
      applyStimulus("rstwait", 1'b1, 1'b0, 3'b010, 32'h8000_0080, 32'd0);
      memAccess("rstwait", 32'h8000_0080, 1'b0, 4'b0000, 32'd0);
      rst = 1'b1;
      #1;
      checkOutput("rstwait req_ready in rst", 32'(req_ready), 32'd0);
      tick();
      checkOutput("rstwait mem_valid", 32'(mem_valid), 32'd0);
      checkOutput("rstwait rsp_valid", 32'(rsp_valid), 32'd0);
      rst        = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hA5A5_A5A5;
      #1;
      checkOutput("rstwait req_ready after", 32'(req_ready), 32'd1);
      tick();
      mem_rvalid = 1'b0;
      mem_rdata  = 32'd0;
      checkOutput("rstwait late rvalid rsp", 32'(rsp_valid), 32'd0);
      checkOutput("rstwait late rvalid mem", 32'(mem_valid), 32'd0);
      checkOutput("rstwait rsp_rdata", rsp_rdata, 32'd0);

      $display("[TB] misaligned word load");
      count_before = access_count;
      applyStimulus("mis", 1'b1, 1'b0, 3'b010, 32'h8000_0002, 32'd0);
`ifdef MISALIGN_CHK_EN
      checkOutput("mis mem_valid", 32'(mem_valid), 32'd0);
      rspAccept("mis", 32'd0, 1'b1);
      checkOutput("mis access count", 32'(access_count - count_before), 32'd0);
`else
      memAccess("mis", 32'h8000_0000, 1'b0, 4'b0000, 32'd0);
      loadReturn("mis", 32'h1122_3344);
      rspAccept("mis", 32'h1122_3344, 1'b0);
      checkOutput("mis access count", 32'(access_count - count_before), 32'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
